// File: rtl/prbs_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions for the shift-register generator and checker.
// Provides the checker state encoding, tap positions, register length and the feedback function.
package prbs_pkg;

    localparam int unsigned PRBS7_LEN   = 7;
    localparam int unsigned PRBS7_TAP_A = 6;
    localparam int unsigned PRBS7_TAP_B = 5;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Next PRBS7 bit predicted from a history whose newest bit sits in bit 0.
    function automatic logic prbs7_fb(input logic [PRBS7_LEN-1:0] s);
        return s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// 7-bit PRBS7 shift/feedback cell.
// Generator mode (self_sync=0): shifts its own feedback bit in on each advance.
// Self-synchronising mode (self_sync=1): shifts ext_bit in, pred_c predicts the next bit.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous zero of the history (highest priority)
//   load         synchronous parallel load of load_val
//   load_val     value for load
//   advance      shift one bit in this cycle
//   self_sync    select ext_bit (1) or internal feedback (0) as the shifted-in bit
//   ext_bit      external bit for self-synchronising mode
//   state        current history, newest bit in state[0]
//   pred_c       combinational prediction of the next bit
module prbs7_lfsr
    import prbs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [PRBS7_LEN-1:0] load_val,
    input  logic                 advance,
    input  logic                 self_sync,
    input  logic                 ext_bit,
    output logic [PRBS7_LEN-1:0] state,
    output logic                 pred_c
);

    assign pred_c = prbs7_fb(state);

    // History register: newest bit enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (clear) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (advance) begin
            state <= {state[PRBS7_LEN-2:0], (self_sync ? ext_bit : pred_c)};
        end
    end

endmodule

// File: rtl/prbs_sr_checker.sv
// Self-synchronising PRBS7 checker for the latch shift-register serial output.
// Seeds its history from the incoming stream, verifies LOCK_CNT consecutive matches, then
// counts compared bits and mismatches while locked. Works for any PRBS7 phase.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       1 = process strobes, 0 = drop samples and hold state
//   clear        synchronous: zero counters and history, return to SEED
//   bit_in       serial data from the shift register
//   bit_strobe   sample bit_in (delayed through the synchroniser with bit_in)
//   locked       checker is in LOCKED
//   err_pulse    one-cycle pulse per mismatch counted while LOCKED
//   lost_lock    one-cycle pulse on LOCKED -> SEED
//   err_count    saturating mismatch count while LOCKED
//   bit_count    saturating compared-bit count while LOCKED
module prbs_sr_checker
    import prbs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = 8,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_strobe,
    output logic             locked,
    output logic             err_pulse,
    output logic             lost_lock,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned SEED_W   = $clog2(PRBS7_LEN);
    localparam int unsigned MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned CONSEC_W = $clog2(UNLOCK_ERRS + 1);

    logic                 bit_s;
    logic                 strobe_s;
    logic                 sample_c;
    logic                 mismatch_c;
    logic                 expected_c;
    logic [PRBS7_LEN-1:0] hist;

    chk_state_t           state;
    logic [SEED_W-1:0]    seed_cnt;
    logic [MATCH_W-1:0]   match_cnt;
    logic [CONSEC_W-1:0]  consec;

    // Synchroniser: strobe travels with the data so they stay aligned.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign bit_s    = bit_in;
            assign strobe_s = bit_strobe;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] bit_sr;
            logic [SYNC_STAGES-1:0] stb_sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bit_sr <= '0;
                    stb_sr <= '0;
                end else begin
                    bit_sr[0] <= bit_in;
                    stb_sr[0] <= bit_strobe;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        bit_sr[i] <= bit_sr[i-1];
                        stb_sr[i] <= stb_sr[i-1];
                    end
                end
            end

            assign bit_s    = bit_sr[SYNC_STAGES-1];
            assign strobe_s = stb_sr[SYNC_STAGES-1];
        end
    endgenerate

    assign sample_c = strobe_s & enable;

    // History cell in self-synchronising mode; clear wins over a same-cycle sample.
    prbs7_lfsr u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (1'b0),
        .load_val  ('0),
        .advance   (sample_c),
        .self_sync (1'b1),
        .ext_bit   (bit_s),
        .state     (hist),
        .pred_c    (expected_c)
    );

    // An all-zero history is the LFSR lock-up state and never counts as a match.
    assign mismatch_c = (bit_s != expected_c) | (hist == '0);

    // Checker FSM with registered flags and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            seed_cnt  <= '0;
            match_cnt <= '0;
            consec    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lost_lock <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            lost_lock <= 1'b0;
            if (clear) begin
                state     <= SEED;
                seed_cnt  <= '0;
                match_cnt <= '0;
                consec    <= '0;
                locked    <= 1'b0;
                err_count <= '0;
                bit_count <= '0;
            end else if (sample_c) begin
                case (state)
                    SEED: begin
                        if (seed_cnt == SEED_W'(PRBS7_LEN - 1)) begin
                            state     <= VERIFY;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            seed_cnt <= seed_cnt + SEED_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (mismatch_c) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            consec    <= '0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (bit_count != '1) begin
                            bit_count <= bit_count + CNT_W'(1);
                        end
                        if (mismatch_c) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (consec == CONSEC_W'(UNLOCK_ERRS - 1)) begin
                                state     <= SEED;
                                locked    <= 1'b0;
                                lost_lock <= 1'b1;
                                consec    <= '0;
                                seed_cnt  <= '0;
                            end else begin
                                consec <= consec + CONSEC_W'(1);
                            end
                        end else begin
                            consec <= '0;
                        end
                    end
                    default: begin
                        state <= SEED;
                    end
                endcase
            end
        end
    end

endmodule
